pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Generic inter-stage pipeline register for the 5-stage CPU. It replaces the fixed
//  per-stage registers (F/D, D/E, E/M, M/W) with one parametrised block.
//  - Payload is NUM_LANES lanes of LANE_W bits each.
//  - Valid/ready handshake, so stalls come from downstream backpressure.
//  - Synchronous flush for branch/exception kills.
//  - Optional skid slot so that in_ready is registered.
// PARAMETERS
//  LANE_W         32  width of one payload lane (pc, instr, ALU result, rdata, ...)
//  NUM_LANES      4   number of lanes; payload width is PW = LANE_W*NUM_LANES
//  CLEAR_ON_FLUSH 1   1: flush zeroes out_data (all-zero instr = nop); 0: out_data holds
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-low reset
//  in_valid   in   1   upstream holds valid payload
//  in_ready   out  1   block can accept this cycle
//  in_data    in   PW  upstream payload
//  flush      in   1   kill all held and incoming payloads this cycle
//  out_valid  out  1   out_data is valid
//  out_ready  in   1   downstream accepts (0 = stall)
//  out_data   out  PW  payload to next stage
//  occupancy  out  2   number of held entries (0..2)
// BEHAVIOUR
//  - Handshake terms:
//    - acc = in_valid & in_ready.
//    - emt = out_valid & out_ready.
//    - Payload transfers only on acc/emt. in_data must stay stable while in_valid=1 & !in_ready.
//  - Reset (rst=0, async): state EMPTY, out_valid=0, out_data=0, skid cleared, occupancy=0.
//    First accept can occur on the first rising edge after rst deasserts.
//  - Latency: 1 cycle. Data accepted at edge N is on out_data after edge N.
//    No combinational path from in_data to out_data.
//  - States:
//    - EMPTY: out_valid=0.
//    - FULL: out register holds one entry.
//    - SKID: out register and skid slot both hold entries (skid build only).
//  - Transitions, skid build:
//    - EMPTY, acc: -> FULL, out<=in_data.
//    - FULL, acc & emt: stay FULL, out<=in_data.
//    - FULL, emt only: -> EMPTY.
//    - FULL, acc only: -> SKID, skid<=in_data.
//    - SKID, emt: -> FULL, out<=skid. No accept is possible in SKID.
//  - Transitions, non-skid build:
//    - Same as above, but without SKID.
//    - FULL with acc only cannot happen, because in_ready=0 when full and stalled.
//  - Flush has priority over every other event:
//    - Next state is EMPTY; out_valid=0; skid dropped; same-cycle in_data discarded.
//    - out_data<=0 if CLEAR_ON_FLUSH, else it holds.
//    - in_ready is not gated by flush.
//    - Downstream must treat an emt in the flush cycle as already consumed.
//  - Backpressure: while out_ready=0, out_data and out_valid stay stable.
//  - occupancy is a registered value: EMPTY=0, FULL=1, SKID=2.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined:
//    - 2-entry skid; in_ready = (state != SKID), driven from a flop.
//    - Sustains 1 transfer per cycle with registered ready.
//  PIPE_STAGE_SKID_EN undefined:
//    - Single entry; in_ready = out_ready | ~out_valid (combinational).
//    - occupancy never exceeds 1.
// STRUCTURE
//  - Package pipe_pkg:
//    - typedef enum {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t.
//    - Lane index localparams (LANE_PC, LANE_INSTR, LANE_ANS, LANE_RDATA).
//    - NOP_INSTR = 32'h0.
//  - Sub-module pipe_skid_slot: PW-bit register plus valid flag, load/clear controls.
//    Instantiated only under PIPE_STAGE_SKID_EN.
// TESTING
//  1. Reset: rst=0 mid-transfer with in_valid=1 -> out_valid=0, out_data=0 and
//     occupancy=0 immediately (async); in_ready=1 after release.
//  2. Streaming: out_ready=1, in_data=1,2,3,4 on consecutive cycles ->
//     out_data=1,2,3,4 one cycle later each, no bubbles.
//  3. Stall, skid build: send A, then B with out_ready=0 -> occupancy=2, in_ready=0.
//     Release -> A then B emitted in order; no loss or duplicate.
//  4. Stall, non-skid build: hold out_ready=0 with in_valid=1 -> in_ready=0
//     combinationally; out_data holds A for the whole stall.
//  5. Flush, CLEAR_ON_FLUSH=1: state SKID, flush=1 with in_valid=1 -> next cycle
//     out_valid=0, out_data=0, occupancy=0, incoming payload dropped.
//  6. Flush and emit together: FULL, out_ready=1, flush=1, in_valid=1 ->
//     EMPTY next cycle; flush wins over acc.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_pkg: shared state encoding and lane layout for the CPU inter-stage registers.
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t;
  localparam int LANE_PC    = 0;
  localparam int LANE_INSTR = 1;
  localparam int LANE_ANS   = 2;
  localparam int LANE_RDATA = 3;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/pipe_stage_reg_skid_slot.sv
// pipe_skid_slot: one-entry overflow register with valid flag; clear wins over load.
module pipe_skid_slot #(
  parameter int PW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [PW-1:0] i_data,
  output logic [PW-1:0] o_data,
  output logic          o_valid
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_data  <= i_data;
      o_valid <= 1'b1;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush; PIPE_STAGE_SKID_EN adds a skid slot
// so in_ready comes from a flop.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int LANE_W         = 32,
  parameter int NUM_LANES      = 4,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  localparam int PW            = LANE_W * NUM_LANES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic [1:0]    occupancy
);
  pipe_state_t   r_state;
  logic          r_out_valid;
  logic [PW-1:0] r_out_data;
  logic [1:0]    r_occ;
  logic          w_acc;
  logic          w_emt;
  assign w_acc     = in_valid & in_ready;
  assign w_emt     = r_out_valid & out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign occupancy = r_occ;
`ifdef PIPE_STAGE_SKID_EN
  logic          r_in_ready;
  logic [PW-1:0] w_skid_data;
  logic          w_skid_valid;
  logic          w_skid_load;
  logic          w_skid_clear;
  assign w_skid_load  = !flush && r_state == ST_FULL && w_acc && !w_emt;
  assign w_skid_clear = flush || (r_state == ST_SKID && w_emt);
  assign in_ready     = r_in_ready;
  pipe_skid_slot #(.PW(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_clear(w_skid_clear),
    .i_data (in_data),
    .o_data (w_skid_data),
    .o_valid(w_skid_valid)
  );
`else
  assign in_ready = out_ready | ~r_out_valid;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_occ       <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      r_in_ready  <= 1'b1;
`endif
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_occ       <= 2'd0;
      if (CLEAR_ON_FLUSH) r_out_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
      r_in_ready  <= 1'b1;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: if (w_acc) begin
          r_state     <= ST_FULL;
          r_out_data  <= in_data;
          r_out_valid <= 1'b1;
          r_occ       <= 2'd1;
        end
        ST_FULL: begin
          if (w_acc && w_emt) r_out_data <= in_data;
          else if (w_emt) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (w_acc) begin
            r_state    <= ST_SKID;
            r_occ      <= 2'd2;
            r_in_ready <= 1'b0;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_SKID: if (w_emt && w_skid_valid) begin
          r_state    <= ST_FULL;
          r_out_data <= w_skid_data;
          r_occ      <= 2'd1;
          r_in_ready <= 1'b1;
        end
`endif
        default: r_state <= ST_EMPTY;
      endcase
    end
endmodule
